pu_int8_array: RTL and testbench

//  Parametrised int8 processing unit: LANES parallel signed int8 MACs computing N_OUT dot products of length K_BEATS*LANES.

---
 rtl/pu_pkg.sv | 33 +++
 rtl/pu_int8_array_if.sv | 59 +++++
 rtl/pu_dot_lane.sv | 23 ++
 rtl/pu_int8_array.sv | 179 +++++++++++++++++
 tb/tb_pu_int8_array.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pu_pkg.sv
// Shared types and helpers for the int8 processing unit.
// Optional requantisation is controlled by the PU_REQUANT_EN macro (see pu_int8_array.sv).
package pu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef logic signed [7:0]  int8_t;
   localparam int ACC_W_DEFAULT = 32;
   typedef logic signed [ACC_W_DEFAULT-1:0] acc_t;
   typedef logic signed [63:0] wide_t;

   // Number of packed int8 lanes in a buffer word.
   function automatic int lanes_of(input int width);
      return width / 8;
   endfunction

   // Clamp a wide signed value into the int8 range.
   function automatic int8_t sat_int8(input wide_t v);
      if (v > 127)
         return 8'sh7f;
      else if (v < -128)
         return 8'sh80;
      else
         return int8_t'(v);
   endfunction

endpackage

// File: rtl/pu_int8_array_if.sv
// Bundle of controller handshake, config and x/w/y buffer signals for pu_int8_array.
// Modport master is taken by the processing unit (it masters the buffer buses);
// modport slave is taken by the surrounding controller/buffers.
// Handshake: prcss_start is a level sampled only while the unit is IDLE or DONE;
// reads are fire-and-forget (data valid exactly one cycle after x/w_buf_en),
// y writes complete in the cycle y_buf_en & y_buf_wr_en are high (no backpressure).
// cfg_shift exists only when PU_REQUANT_EN is defined.
interface pu_int8_array_if #(
   parameter int IN_X_BUF_DATA_WIDTH = 32,
   parameter int IN_W_BUF_DATA_WIDTH = 32,
   parameter int IN_BUF_ADDR_WIDTH   = 16,
   parameter int OUT_BUF_ADDR_WIDTH  = 32,
   parameter int OUT_BUF_DATA_WIDTH  = 32,
   parameter int CFG_W               = 16
);
   logic                           prcss_start;
   logic [CFG_W-1:0]               cfg_k_beats;
   logic [CFG_W-1:0]               cfg_n_out;
   logic [OUT_BUF_ADDR_WIDTH-1:0]  cfg_y_base;
`ifdef PU_REQUANT_EN
   logic [4:0]                     cfg_shift;
`endif
   logic                           prcss_done;
   logic                           all_done;
   logic                           x_buf_en;
   logic [IN_BUF_ADDR_WIDTH-1:0]   x_buf_addr;
   logic [IN_X_BUF_DATA_WIDTH-1:0] x_buf_data;
   logic                           w_buf_en;
   logic [IN_BUF_ADDR_WIDTH-1:0]   w_buf_addr;
   logic [IN_W_BUF_DATA_WIDTH-1:0] w_buf_data;
   logic                           y_buf_en;
   logic                           y_buf_wr_en;
   logic [OUT_BUF_ADDR_WIDTH-1:0]  y_buf_addr;
   logic [OUT_BUF_DATA_WIDTH-1:0]  y_buf_data;

`ifdef PU_REQUANT_EN
   modport master (
      input  prcss_start, cfg_k_beats, cfg_n_out, cfg_y_base, cfg_shift, x_buf_data, w_buf_data,
      output prcss_done, all_done, x_buf_en, x_buf_addr, w_buf_en, w_buf_addr,
             y_buf_en, y_buf_wr_en, y_buf_addr, y_buf_data
   );
   modport slave (
      output prcss_start, cfg_k_beats, cfg_n_out, cfg_y_base, cfg_shift, x_buf_data, w_buf_data,
      input  prcss_done, all_done, x_buf_en, x_buf_addr, w_buf_en, w_buf_addr,
             y_buf_en, y_buf_wr_en, y_buf_addr, y_buf_data
   );
`else
   modport master (
      input  prcss_start, cfg_k_beats, cfg_n_out, cfg_y_base, x_buf_data, w_buf_data,
      output prcss_done, all_done, x_buf_en, x_buf_addr, w_buf_en, w_buf_addr,
             y_buf_en, y_buf_wr_en, y_buf_addr, y_buf_data
   );
   modport slave (
      output prcss_start, cfg_k_beats, cfg_n_out, cfg_y_base, x_buf_data, w_buf_data,
      input  prcss_done, all_done, x_buf_en, x_buf_addr, w_buf_en, w_buf_addr,
             y_buf_en, y_buf_wr_en, y_buf_addr, y_buf_data
   );
`endif
endinterface

// File: rtl/pu_dot_lane.sv
// Combinational LANES-wide signed int8 dot product of one x word and one w word.
module pu_dot_lane #(
   parameter int LANES = 4,
   parameter int ACC_W = 32
) (
   input  logic [LANES*8-1:0]       x,
   input  logic [LANES*8-1:0]       w,
   output logic signed [ACC_W-1:0]  psum
);

   logic signed [15:0] prod;

   // Multiply each byte pair as signed int8 and reduce to one sign-extended sum.
   always_comb begin
      psum = '0;
      prod = '0;
      for (int i = 0; i < LANES; i++) begin
         prod = $signed(x[8*i +: 8]) * $signed(w[8*i +: 8]);
         psum = psum + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/pu_int8_array.sv
// Int8 processing unit: N_OUT dot products of K_BEATS words each, one y write per output.
// Optional feature macro: PU_REQUANT_EN (adds cfg_shift; round-half-up shift then int8 clamp).
module pu_int8_array
   import pu_pkg::*;
#(
   parameter int IN_X_BUF_DATA_WIDTH = 32,
   parameter int IN_W_BUF_DATA_WIDTH = 32,
   parameter int IN_BUF_ADDR_WIDTH   = 16,
   parameter int OUT_BUF_ADDR_WIDTH  = 32,
   parameter int OUT_BUF_DATA_WIDTH  = 32,
   parameter int ACC_W               = 32,
   parameter int CFG_W               = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   pu_int8_array_if.master   bus,
   output state_t            dbg_state
);

   localparam int IN_W_MIN = (IN_X_BUF_DATA_WIDTH < IN_W_BUF_DATA_WIDTH) ?
                             IN_X_BUF_DATA_WIDTH : IN_W_BUF_DATA_WIDTH;
   localparam int LANES    = lanes_of(IN_W_MIN);
   localparam int LW       = LANES * 8;

   state_t                         state_q, state_d;
   logic [CFG_W-1:0]               k_q, k_d, n_q, n_d;
   logic [IN_BUF_ADDR_WIDTH-1:0]   w_q, w_d;
   logic [CFG_W-1:0]               cfg_k_q, cfg_n_q;
   logic [OUT_BUF_ADDR_WIDTH-1:0]  base_q;
   logic                           start_ok;
   logic                           beat_vld_q, beat_first_q;
   logic signed [ACC_W-1:0]        acc_q, psum;
   logic                           rd_en_q, y_en_q, done_q, all_done_q;
   logic [OUT_BUF_ADDR_WIDTH-1:0]  y_addr_q;
   logic [OUT_BUF_DATA_WIDTH-1:0]  result;

   pu_dot_lane #(.LANES(LANES), .ACC_W(ACC_W)) u_dot (
      .x    (bus.x_buf_data[LW-1:0]),
      .w    (bus.w_buf_data[LW-1:0]),
      .psum (psum)
   );

   // Next-state and counter logic; k returns to 0 when leaving RUN so x address idles at 0.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      n_d      = n_q;
      w_d      = w_q;
      start_ok = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE) state_d = IDLE;
            if (bus.prcss_start) begin
               start_ok = 1'b1;
               k_d      = '0;
               n_d      = '0;
               w_d      = '0;
               if (bus.cfg_k_beats == '0 || bus.cfg_n_out == '0) state_d = DONE;
               else                                              state_d = RUN;
            end
         end
         RUN: begin
            w_d = w_q + IN_BUF_ADDR_WIDTH'(1);
            if (k_q == cfg_k_q - CFG_W'(1)) begin
               k_d     = '0;
               state_d = DRAIN;
            end else begin
               k_d = k_q + CFG_W'(1);
            end
         end
         DRAIN: state_d = WRITE;
         WRITE: begin
            n_d = n_q + CFG_W'(1);
            if (n_q == cfg_n_q - CFG_W'(1)) state_d = DONE;
            else                            state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and registered enables/addresses derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         k_q        <= '0;
         n_q        <= '0;
         w_q        <= '0;
         rd_en_q    <= 1'b0;
         y_en_q     <= 1'b0;
         y_addr_q   <= '0;
         done_q     <= 1'b0;
         all_done_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         n_q      <= n_d;
         w_q      <= w_d;
         rd_en_q  <= (state_d == RUN);
         y_en_q   <= (state_d == WRITE);
         y_addr_q <= (state_d == WRITE) ? base_q + OUT_BUF_ADDR_WIDTH'(n_d) : '0;
         done_q   <= (state_d == DONE);
         if (state_d == DONE) all_done_q <= 1'b1;
         else if (start_ok)   all_done_q <= 1'b0;
      end
   end

`ifdef PU_REQUANT_EN
   logic [4:0] shift_q;
   wide_t      acc_wide, bias, rounded;

   // Capture the job configuration when a start is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_k_q <= '0;
         cfg_n_q <= '0;
         base_q  <= '0;
         shift_q <= '0;
      end else if (start_ok) begin
         cfg_k_q <= bus.cfg_k_beats;
         cfg_n_q <= bus.cfg_n_out;
         base_q  <= bus.cfg_y_base;
         shift_q <= bus.cfg_shift;
      end
   end

   // Round half up at the shift point, arithmetic shift, clamp to int8, sign-extend.
   always_comb begin
      acc_wide = wide_t'(acc_q);
      bias     = '0;
      if (shift_q != 5'd0) bias = wide_t'(1) <<< (shift_q - 5'd1);
      rounded  = (acc_wide + bias) >>> shift_q;
      result   = OUT_BUF_DATA_WIDTH'(sat_int8(rounded));
   end
`else
   // Capture the job configuration when a start is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_k_q <= '0;
         cfg_n_q <= '0;
         base_q  <= '0;
      end else if (start_ok) begin
         cfg_k_q <= bus.cfg_k_beats;
         cfg_n_q <= bus.cfg_n_out;
         base_q  <= bus.cfg_y_base;
      end
   end

   // Raw accumulator, sign-extended or truncated to the y word.
   always_comb begin
      result = OUT_BUF_DATA_WIDTH'(acc_q);
   end
`endif

   // Read data arrives one cycle after each RUN beat; the first beat of an output restarts the sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_vld_q   <= 1'b0;
         beat_first_q <= 1'b0;
         acc_q        <= '0;
      end else begin
         beat_vld_q   <= (state_q == RUN);
         beat_first_q <= (state_q == RUN) && (k_q == '0);
         if (beat_vld_q) acc_q <= beat_first_q ? psum : acc_q + psum;
      end
   end

   assign bus.x_buf_en    = rd_en_q;
   assign bus.w_buf_en    = rd_en_q;
   assign bus.x_buf_addr  = IN_BUF_ADDR_WIDTH'(k_q);
   assign bus.w_buf_addr  = w_q;
   assign bus.y_buf_en    = y_en_q;
   assign bus.y_buf_wr_en = y_en_q;
   assign bus.y_buf_addr  = y_addr_q;
   assign bus.y_buf_data  = y_en_q ? result : '0;
   assign bus.prcss_done  = done_q;
   assign bus.all_done    = all_done_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_pu_int8_array.sv
// Self-checking bench for pu_int8_array with behavioural x/w memories and a dot-product model.
// Build with PU_REQUANT_EN defined to also cover the requantised output path.
module tb_pu_int8_array;
   import pu_pkg::*;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_t dbg_state;

   int checks   = 0;
   int failures = 0;
   int cur_shift = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_addr_q[$];
   logic [15:0] exp_x_q[$];
   logic [15:0] exp_w_q[$];

   logic [31:0] x_mem[64];
   logic [31:0] w_mem[256];

   pu_int8_array_if bus ();

   pu_int8_array dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Synchronous-read buffers: data one cycle after enable, junk otherwise.
   always @(posedge clk) begin
      bus.x_buf_data <= bus.x_buf_en ? x_mem[bus.x_buf_addr[5:0]] : $urandom;
      bus.w_buf_data <= bus.w_buf_en ? w_mem[bus.w_buf_addr[7:0]] : $urandom;
   end

   // Watchdog
   initial begin
      #3000000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1);
   end

   function automatic logic [101:0] out_bits();
      return {bus.x_buf_addr, bus.w_buf_addr, bus.y_buf_addr, bus.y_buf_data,
              bus.x_buf_en, bus.w_buf_en, bus.y_buf_en, bus.y_buf_wr_en,
              bus.prcss_done, bus.all_done};
   endfunction

   // Expected y word from the exact (unbounded) dot product.
   function automatic logic [31:0] ref_result(input longint sum);
      longint a;
`ifdef PU_REQUANT_EN
      longint d, q;
`endif
      a = longint'($signed(sum[31:0]));
`ifdef PU_REQUANT_EN
      d = longint'(1) << cur_shift;
      if (cur_shift > 0) a = a + d / 2;
      if (a >= 0) q = a / d;
      else        q = -((-a + d - 1) / d);
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      return q[31:0];
`else
      return a[31:0];
`endif
   endfunction

   task automatic build_expect(input int k, input int n, input logic [31:0] base);
      logic [31:0] xv, wv;
      byte         xb, wb;
      longint      s;
      exp_q.delete(); exp_addr_q.delete(); exp_x_q.delete(); exp_w_q.delete();
      if (k == 0 || n == 0) return;
      for (int nn = 0; nn < n; nn++) begin
         s = 0;
         for (int kk = 0; kk < k; kk++) begin
            xv = x_mem[kk];
            wv = w_mem[nn * k + kk];
            for (int i = 0; i < 4; i++) begin
               xb = xv[8*i +: 8];
               wb = wv[8*i +: 8];
               s  = s + longint'(xb) * longint'(wb);
            end
            exp_x_q.push_back(16'(kk));
            exp_w_q.push_back(16'(nn * k + kk));
         end
         exp_q.push_back(ref_result(s));
         exp_addr_q.push_back(base + 32'(nn));
      end
   endtask

   // Drive one job and check every read beat, write, and the done timing.
   task automatic run_job(input int k, input int n, input logic [31:0] base,
                          input bit chained, input int glitch_cyc, input string name);
      int          done_cyc, limit;
      bit          seen_done, zero_job;
      logic [15:0] ex, ew;
      logic [31:0] ed, ea;
      build_expect(k, n, base);
      zero_job = (k == 0 || n == 0);
      if (!chained) @(negedge clk);
      bus.prcss_start = 1'b1;
      bus.cfg_k_beats = 16'(k);
      bus.cfg_n_out   = 16'(n);
      bus.cfg_y_base  = base;
`ifdef PU_REQUANT_EN
      bus.cfg_shift   = 5'(cur_shift);
`endif
      done_cyc  = zero_job ? 1 : n * (k + 2) + 1;
      limit     = done_cyc + 8;
      seen_done = 1'b0;
      for (int cyc = 1; cyc <= limit && !seen_done; cyc++) begin
         @(negedge clk);
         bus.prcss_start = (cyc == glitch_cyc);
         if (cyc == glitch_cyc) begin
            bus.cfg_k_beats = 16'd1;
            bus.cfg_n_out   = 16'd1;
            bus.cfg_y_base  = 32'hdead_0000;
         end
         if (cyc == 1) begin
            checks++;
            if (bus.all_done !== zero_job) begin
               failures++;
               $display("FAIL %s all_done_c1 got %0b exp %0b", name, bus.all_done, zero_job);
            end
         end
         if (bus.x_buf_en || bus.w_buf_en) begin
            checks++;
            if (exp_x_q.size() == 0) begin
               failures++;
               $display("FAIL %s read_beat unexpected read at cycle %0d", name, cyc);
            end else begin
               ex = exp_x_q.pop_front();
               ew = exp_w_q.pop_front();
               if (bus.x_buf_en !== 1'b1 || bus.w_buf_en !== 1'b1 ||
                   bus.x_buf_addr !== ex || bus.w_buf_addr !== ew) begin
                  failures++;
                  $display("FAIL %s read_beat got en=%0b%0b x=%0h w=%0h exp x=%0h w=%0h",
                           name, bus.x_buf_en, bus.w_buf_en, bus.x_buf_addr, bus.w_buf_addr, ex, ew);
               end
            end
         end
         if (bus.y_buf_en || bus.y_buf_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL %s y_write unexpected write at cycle %0d", name, cyc);
            end else begin
               ed = exp_q.pop_front();
               ea = exp_addr_q.pop_front();
               if (bus.y_buf_wr_en !== 1'b1 || bus.y_buf_en !== 1'b1 ||
                   bus.y_buf_addr !== ea || bus.y_buf_data !== ed) begin
                  failures++;
                  $display("FAIL %s y_write got en=%0b%0b addr=%0h data=%0h exp addr=%0h data=%0h",
                           name, bus.y_buf_en, bus.y_buf_wr_en, bus.y_buf_addr, bus.y_buf_data, ea, ed);
               end
            end
         end
         if (bus.prcss_done) begin
            seen_done = 1'b1;
            checks++;
            if (cyc != done_cyc || bus.all_done !== 1'b1) begin
               failures++;
               $display("FAIL %s done_timing got cycle=%0d all_done=%0b exp cycle=%0d all_done=1",
                        name, cyc, bus.all_done, done_cyc);
            end
         end
      end
      if (!seen_done) begin
         failures++;
         $display("FAIL %s done_timeout no prcss_done within %0d cycles", name, limit);
      end
      checks++;
      if (exp_q.size() != 0 || exp_x_q.size() != 0) begin
         failures++;
         $display("FAIL %s leftover got %0d writes %0d reads missing exp 0", name, exp_q.size(), exp_x_q.size());
      end
   endtask

   task automatic test_reset();
      bus.prcss_start = 1'b0;
      bus.cfg_k_beats = '0;
      bus.cfg_n_out   = '0;
      bus.cfg_y_base  = '0;
`ifdef PU_REQUANT_EN
      bus.cfg_shift   = '0;
`endif
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_bits() !== '0 || dbg_state !== IDLE) begin
         failures++;
         $display("FAIL reset_hold got outs=%0h state=%0d exp 0 and IDLE", out_bits(), dbg_state);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out_bits() !== '0 || dbg_state !== IDLE) begin
         failures++;
         $display("FAIL reset_release got outs=%0h state=%0d exp 0 and IDLE", out_bits(), dbg_state);
      end
   endtask

   task automatic test_basic();
      x_mem[0] = 32'h0102_0304;
      w_mem[0] = 32'h0101_0101;
      run_job(1, 1, 32'h0000_0100, 1'b0, 0, "basic");
      @(negedge clk);
      checks++;
      if (bus.prcss_done !== 1'b0 || dbg_state !== IDLE || bus.all_done !== 1'b1) begin
         failures++;
         $display("FAIL basic_after_done got done=%0b state=%0d all_done=%0b exp 0 IDLE 1",
                  bus.prcss_done, dbg_state, bus.all_done);
      end
   endtask

   task automatic test_extremes();
      for (int i = 0; i < 4; i++) x_mem[i] = 32'h7f7f_7f7f;
      for (int i = 0; i < 12; i++) w_mem[i] = 32'h8080_8080;
      run_job(4, 3, 32'h0000_2000, 1'b0, 0, "extremes");
   endtask

   task automatic test_zero_len();
      run_job(0, 5, 32'h0000_0300, 1'b0, 0, "zero_k");
      run_job(3, 0, 32'h0000_0300, 1'b0, 0, "zero_n");
   endtask

   task automatic test_random();
      int          k, n;
      logic [31:0] base;
      for (int j = 0; j < 6; j++) begin
         for (int i = 0; i < 64; i++)  x_mem[i] = $urandom;
         for (int i = 0; i < 256; i++) w_mem[i] = $urandom;
         k    = $urandom_range(1, 6);
         n    = $urandom_range(1, 4);
         base = (j == 0) ? 32'hffff_fffe : $urandom;
         run_job(k, n, base, 1'b0, 0, "random");
      end
   endtask

   task automatic test_ignored_start();
      for (int i = 0; i < 64; i++)  x_mem[i] = $urandom;
      for (int i = 0; i < 256; i++) w_mem[i] = $urandom;
      run_job(3, 2, 32'h0000_0040, 1'b0, 2, "start_mid_run");
   endtask

   task automatic test_reset_mid_run();
      bit wrote;
      @(negedge clk);
      bus.prcss_start = 1'b1;
      bus.cfg_k_beats = 16'd6;
      bus.cfg_n_out   = 16'd2;
      bus.cfg_y_base  = 32'h0000_0080;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         bus.prcss_start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_bits() !== '0 || dbg_state !== IDLE) begin
         failures++;
         $display("FAIL reset_mid_run got outs=%0h state=%0d exp 0 and IDLE", out_bits(), dbg_state);
      end
      wrote = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.y_buf_en || bus.y_buf_wr_en) wrote = 1'b1;
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (bus.y_buf_en || bus.y_buf_wr_en) wrote = 1'b1;
      end
      checks++;
      if (wrote || bus.all_done !== 1'b0 || dbg_state !== IDLE) begin
         failures++;
         $display("FAIL reset_no_write got wrote=%0b all_done=%0b state=%0d exp 0 0 IDLE",
                  wrote, bus.all_done, dbg_state);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 64; i++)  x_mem[i] = $urandom;
      for (int i = 0; i < 256; i++) w_mem[i] = $urandom;
      run_job(2, 2, 32'h0000_0500, 1'b0, 0, "b2b_first");
      run_job(5, 1, 32'h0000_0a00, 1'b1, 0, "b2b_second");
      run_job(0, 1, 32'h0000_0b00, 1'b1, 0, "b2b_zero");
      run_job(1, 3, 32'h0000_0c00, 1'b1, 0, "b2b_third");
   endtask

`ifdef PU_REQUANT_EN
   task automatic test_requant();
      // lane 0 only: 100*10 = 1000
      x_mem[0] = 32'h0000_0064;
      w_mem[0] = 32'h0000_000a;
      cur_shift = 4;
      run_job(1, 1, 32'h0000_0600, 1'b0, 0, "requant_pos");
      // -100*50 = -5000
      x_mem[0] = 32'h0000_009c;
      w_mem[0] = 32'h0000_0032;
      run_job(1, 1, 32'h0000_0601, 1'b0, 0, "requant_neg_sat");
      // 100*20 = 2000 with no shift
      x_mem[0] = 32'h0000_0064;
      w_mem[0] = 32'h0000_0014;
      cur_shift = 0;
      run_job(1, 1, 32'h0000_0602, 1'b0, 0, "requant_pos_sat");
      for (int i = 0; i < 64; i++)  x_mem[i] = $urandom;
      for (int i = 0; i < 256; i++) w_mem[i] = $urandom;
      cur_shift = $urandom_range(1, 20);
      run_job(4, 2, 32'h0000_0700, 1'b0, 0, "requant_random");
      cur_shift = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_zero_len();
      test_random();
      test_ignored_start();
      test_reset_mid_run();
      test_back_to_back();
`ifdef PU_REQUANT_EN
      test_requant();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
